// File: rtl/snn_lif_layer.sv
// Leaky-integrate-and-fire neuron layer: per time-step leak, weight-row scan over active
// inputs, threshold fire with saturating arithmetic and saturating per-neuron spike counts.
module snn_lif_layer #(
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned WEIGHT_W    = 8,
  parameter int unsigned POT_W       = 16,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned RESET_MODE  = 0,
  parameter int unsigned AW          = $clog2(NUM_INPUTS)
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            start,
  input  logic                            clear,
  input  logic [NUM_INPUTS-1:0]           in_spikes,
  input  logic [POT_W-1:0]                threshold,
  input  logic [3:0]                      leak_shift,
  output logic                            w_rd,
  output logic [AW-1:0]                   w_addr,
  input  logic [NUM_NEURONS*WEIGHT_W-1:0] w_data,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_NEURONS-1:0]          out_spikes,
  output logic [NUM_NEURONS*COUNT_W-1:0]  spike_count
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLeak  = 3'd1;
  localparam logic [2:0] StScan  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StFire  = 3'd4;

  localparam logic [AW-1:0] LastIdx = AW'(NUM_INPUTS - 1);

  logic [2:0]                                state_q, state_d;
  logic [NUM_INPUTS-1:0]                     spk_q, spk_d;
  logic [NUM_NEURONS-1:0][POT_W-1:0]         pot_q, pot_d;
  logic [NUM_NEURONS-1:0][COUNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_NEURONS-1:0]                    out_q, out_d;
  logic                                      busy_q, busy_d;
  logic                                      done_q, done_d;
  logic                                      rd_q, rd_d;
  logic                                      vld_q;
  logic [AW-1:0]                             addr_q, addr_d;

  // Sum/difference of two POT_W values fits POT_W+1 bits; clamp on sign disagreement.
  function automatic logic [POT_W-1:0] sat(input logic [POT_W:0] v);
    if (v[POT_W] != v[POT_W-1]) begin
      sat = {v[POT_W], {(POT_W-1){~v[POT_W]}}};
    end else begin
      sat = v[POT_W-1:0];
    end
  endfunction

  function automatic logic [POT_W:0] ext(input logic [POT_W-1:0] p);
    ext = {p[POT_W-1], p};
  endfunction

  always_comb begin
    logic [POT_W-1:0]    lk;
    logic [WEIGHT_W-1:0] w;
    state_d = state_q;
    spk_d   = spk_q;
    pot_d   = pot_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    lk      = '0;
    w       = '0;

    // Row data arrives the cycle after its read strobe.
    if (vld_q) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        w        = w_data[n*WEIGHT_W +: WEIGHT_W];
        pot_d[n] = sat(ext(pot_q[n]) + {{(POT_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w});
      end
    end

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          pot_d = '0;
          cnt_d = '0;
        end else if (start) begin
          spk_d   = in_spikes;
          busy_d  = 1'b1;
          state_d = StLeak;
        end
      end
      StLeak: begin
        if (leak_shift != 4'd0) begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            lk       = $signed(pot_q[n]) >>> leak_shift;
            pot_d[n] = sat(ext(pot_q[n]) - ext(lk));
          end
        end
        rd_d    = spk_q[0];
        spk_d   = spk_q >> 1;
        addr_d  = '0;
        state_d = StScan;
      end
      StScan: begin
        if (addr_q == LastIdx) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + AW'(1);
          rd_d   = spk_q[0];
          spk_d  = spk_q >> 1;
        end
      end
      StDrain: state_d = StFire;
      StFire: begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
          out_d[n] = $signed(pot_q[n]) >= $signed(threshold);
          if (out_d[n]) begin
            if (RESET_MODE == 0) pot_d[n] = '0;
            else pot_d[n] = sat(ext(pot_q[n]) - ext(threshold));
            if (cnt_q[n] != {COUNT_W{1'b1}}) cnt_d[n] = cnt_q[n] + COUNT_W'(1);
          end
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      spk_q   <= '0;
      pot_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      spk_q   <= spk_d;
      pot_q   <= pot_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      vld_q   <= rd_q;
      addr_q  <= addr_d;
    end
  end

  assign w_rd        = rd_q;
  assign w_addr      = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_spikes  = out_q;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_snn_lif_layer.sv
// Randomised bench for snn_lif_layer against an integer reference model of the LIF rules.
module tb_snn_lif_layer;
  localparam int NI = 4, NN = 3, WW = 6, PW = 8, CW = 3, RM = 1, AW = 2;
  localparam int DW = NN * WW;
  localparam int PMAX = 127, PMIN = -128, CMAX = 7;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
  logic [NI-1:0]    in_spikes = '0;
  logic [PW-1:0]    threshold = '0;
  logic [3:0]       leak_shift = '0;
  logic             w_rd;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data = '0;
  logic             busy, done;
  logic [NN-1:0]    out_spikes;
  logic [NN*CW-1:0] spike_count;

  int wmem[NI][NN];
  int pot[NN];
  int cnt[NN];
  logic [NN-1:0] exp_out;
  int n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  snn_lif_layer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .WEIGHT_W(WW), .POT_W(PW),
    .COUNT_W(CW), .RESET_MODE(RM), .AW(AW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .clear(clear),
    .in_spikes(in_spikes), .threshold(threshold), .leak_shift(leak_shift),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done),
    .out_spikes(out_spikes), .spike_count(spike_count)
  );

  // Weight SRAM: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (w_rd) begin
      for (int n = 0; n < NN; n++) w_data[n*WW +: WW] <= WW'(wmem[w_addr][n]);
    end else begin
      w_data <= DW'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int clamp(input int v);
    if (v > PMAX) return PMAX;
    if (v < PMIN) return PMIN;
    return v;
  endfunction

  task automatic model_step(input logic [NI-1:0] sp, input int thr, input int sh);
    for (int n = 0; n < NN; n++) if (sh != 0) pot[n] = clamp(pot[n] - (pot[n] >>> sh));
    for (int i = 0; i < NI; i++)
      if (sp[i]) for (int n = 0; n < NN; n++) pot[n] = clamp(pot[n] + wmem[i][n]);
    for (int n = 0; n < NN; n++) begin
      exp_out[n] = (pot[n] >= thr);
      if (exp_out[n]) begin
        pot[n] = (RM == 0) ? 0 : clamp(pot[n] - thr);
        if (cnt[n] < CMAX) cnt[n]++;
      end
    end
  endtask

  task automatic check_counts(input string tag);
    for (int n = 0; n < NN; n++)
      chk($sformatf("%s_cnt%0d", tag, n), spike_count[n*CW +: CW], cnt[n]);
  endtask

  task automatic rand_weights();
    for (int i = 0; i < NI; i++)
      for (int n = 0; n < NN; n++) wmem[i][n] = int'($urandom_range(0, 63)) - 32;
  endtask

  // Caller is at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_step(input logic [NI-1:0] sp, input int thr, input int sh,
                          input bit poke);
    int cyc, stray;
    logic [NI-1:0] rd_mask;
    start = 1'b1; in_spikes = sp; threshold = PW'(thr); leak_shift = 4'(sh);
    @(negedge clk);
    start = 1'b0; in_spikes = NI'($urandom);
    chk("busy_set", busy, 1);
    cyc = 1; stray = 0; rd_mask = '0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc >= 2 && cyc <= NI + 1) begin
        chk("w_addr", w_addr, cyc - 2);
        if (w_rd) rd_mask[cyc-2] = 1'b1;
      end else if (w_rd) begin
        stray++;
      end
      if (poke && cyc == 3) begin start = 1'b1; clear = 1'b1; end
      else begin start = 1'b0; clear = 1'b0; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; clear = 1'b0;
    model_step(sp, thr, sh);
    chk("latency", cyc, NI + 4);
    chk("rd_mask", rd_mask, sp);
    chk("stray_rd", stray, 0);
    chk("busy_clr", busy, 0);
    chk("out_spikes", out_spikes, exp_out);
    check_counts("step");
  endtask

  task automatic do_clear(input bit with_start);
    clear = 1'b1; start = with_start; in_spikes = '1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    for (int n = 0; n < NN; n++) begin pot[n] = 0; cnt[n] = 0; end
    chk("clr_busy", busy, 0);
    chk("clr_out", out_spikes, exp_out);
    check_counts("clr");
  endtask

  initial begin
    int bad;
    rand_weights();
    for (int n = 0; n < NN; n++) begin pot[n] = 0; cnt[n] = 0; end
    exp_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_rd", w_rd, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_out", out_spikes, 0);
    chk("rst_count", spike_count, 0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || w_rd || w_addr != 0 || out_spikes != 0 || spike_count != 0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Basic fire: n0 = 6+5 = 11 >= 10, n1 = 2-3 = -1
    wmem[0][0] = 6; wmem[0][1] = 2; wmem[2][0] = 5; wmem[2][1] = -3;
    run_step(4'b0101, 10, 0, 1'b0);
    chk("basic_fire_n0", out_spikes[0], 1);
    chk("basic_quiet_n1", out_spikes[1], 0);
    chk("basic_cnt_n0", spike_count[CW-1:0], 1);

    // Leak: preload n0 to 40, then 40 - 40/4 = 30 fires at threshold 30
    do_clear(1'b1);
    wmem[0][0] = 20; wmem[1][0] = 20;
    run_step(4'b0011, 100, 0, 1'b0);
    run_step(4'b0000, 30, 2, 1'b0);
    chk("leak_fire_n0", out_spikes[0], 1);
    run_step(4'b0000, 30, 2, 1'b0);
    chk("leak_empty_n0", out_spikes[0], 0);

    // Saturation: large positive weights must clamp, never wrap
    for (int i = 0; i < NI; i++) for (int n = 0; n < NN; n++) wmem[i][n] = 31;
    repeat (16) run_step(4'b1111, 127, 0, 1'b0);
    chk("sat_cnt_n0", spike_count[CW-1:0], CMAX);

    // start/clear while busy are ignored
    rand_weights();
    run_step(NI'($urandom), 40, 1, 1'b1);
    @(negedge clk);
    chk("no_extra_done", done, 0);
    run_step(NI'($urandom), 40, 1, 1'b0);

    // Randomised steps with occasional gaps, clears and weight reloads
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) rand_weights();
      if ($urandom_range(0, 14) == 0) do_clear(1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_step(NI'($urandom), int'($urandom_range(0, 110)) - 10,
               int'($urandom_range(0, 15)), 1'($urandom_range(0, 5) == 0));
    end

    // Reset mid-SCAN with every input active
    @(negedge clk);
    start = 1'b1; in_spikes = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_rd", w_rd, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_w_rd", w_rd, 0);
    chk("mid_rst_out", out_spikes, 0);
    chk("mid_rst_count", spike_count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < NN; n++) begin pot[n] = 0; cnt[n] = 0; end
    exp_out = '0;
    rand_weights();
    run_step(NI'($urandom), 20, 0, 1'b0);
    run_step(NI'($urandom), 20, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
